// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider (signed/unsigned), result {rem, quo}.
// Optional macro DIV_ZERO_FASTPATH_EN routes a zero divisor through BYZERO with a zero result.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FREE   | idle, waiting for start_i without annul_i
// S_BYZERO | zero divisor seen (fast path only), result forced to 0
// S_ON     | restoring iterations, one quotient bit per edge
// S_END    | result valid, held while start_i stays high
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_ON     = 2'd1,
`ifdef DIV_ZERO_FASTPATH_EN
    S_BYZERO = 2'd3,
`endif
    S_END    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        op_neg1, op_neg2;
  logic [31:0] mag1, mag2;
  logic [32:0] trial, diff;
  logic        take;
  logic [31:0] quo_fix, rem_fix;
  logic        go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    go = start_i & ~annul_i;
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (go) begin
`ifdef DIV_ZERO_FASTPATH_EN
          state_d = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
`else
          state_d = S_ON;
`endif
        end
      end
`ifdef DIV_ZERO_FASTPATH_EN
      S_BYZERO: state_d = annul_i ? S_FREE : S_END;
`endif
      S_ON: begin
        if (annul_i)              state_d = S_FREE;
        else if (cnt_q == 6'd32)  state_d = S_END;
      end
      S_END:   if (!start_i) state_d = S_FREE;
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    op_neg1 = signed_div_i & opdata1_i[31];
    op_neg2 = signed_div_i & opdata2_i[31];
    mag1    = op_neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
    mag2    = op_neg2 ? (~opdata2_i + 32'd1) : opdata2_i;
    trial   = {rem_q, quo_q[31]};
    take    = (trial >= {1'b0, dvs_q});
    diff    = trial - {1'b0, dvs_q};
    // Signs were latched at capture, so correction does not depend on signed_div_i now.
    quo_fix = (neg1_q ^ neg2_q) ? (~quo_q + 32'd1) : quo_q;
    rem_fix = neg1_q ? (~rem_q + 32'd1) : rem_q;

    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_FREE: begin
        if (go) begin
          cnt_d  = 6'd0;
          quo_d  = mag1;
          rem_d  = 32'd0;
          dvs_d  = mag2;
          neg1_d = op_neg1;
          neg2_d = op_neg2;
        end
      end
`ifdef DIV_ZERO_FASTPATH_EN
      S_BYZERO: begin
        if (!annul_i) begin
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end
`endif
      S_ON: begin
        if (!annul_i) begin
          if (cnt_q == 6'd32) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end else begin
            rem_d = take ? diff[31:0] : trial[31:0];
            quo_d = {quo_q[30:0], take};
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy_o   = (state_q != S_FREE);
    result_o = result_q;
    ready_o  = ready_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; directed vectors with hand-computed results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising ready_o pops one expectation.
  logic ready_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && ready_o && !ready_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result_o, mon_e.res);
        chk("latency", 64'(edge_cnt - mon_e.start_edge), 64'(mon_e.lat));
      end
    end
    ready_prev = ready_o;
  end

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int k;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb.push_back('{exp, lat, edge_cnt + 1});
    @(negedge clk);
    chk("busy_after_start", 64'(busy_o), 64'd1);
    k = 0;
    while (!ready_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_seen", 64'(ready_o), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, exp);
      chk("hold_busy", 64'(busy_o), 64'd1);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("release_ready", 64'(ready_o), 64'd0);
    chk("release_result", result_o, 64'd0);
    chk("release_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 3);
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
    run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
    run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33, 1);
    run_op(1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33, 0);
`ifdef DIV_ZERO_FASTPATH_EN
    run_op(1'b0, 32'h00000005, 32'h00000000, 64'h0, 1, 2);
    run_op(1'b1, 32'hFFFFFFFB, 32'h00000000, 64'h0, 1, 0);
`else
    run_op(1'b0, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 33, 2);
    run_op(1'b1, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_00000001, 33, 0);
`endif

    // Annul at edge N+10, then a fresh 9/3 sampled at N+12.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'd0);
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Reset at edge N+20 while start_i is still high.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    start_i = 1'b0;
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
